// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage
// and external data memory: 4-word lines filled in one transfer, single-cycle read hits.
module data_cache #(
  parameter int unsigned INDEX_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 14 - INDEX_BITS;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned LINE_W   = 4 * WORD_W;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_e;

  state_e state_q, state_d;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;

  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic [15:0]         hit_count_q, hit_count_d;
  logic [15:0]         miss_count_q, miss_count_d;

  logic        hit_c, read_hit_c, fill_done_c, write_done_c;
  logic [5:0]  word_base_c;
  logic [15:0] cached_word_c, fill_word_c;

  assign offset = cpu_address[1:0];
  assign index  = cpu_address[INDEX_BITS+1:2];
  assign tag    = cpu_address[15:INDEX_BITS+2];

  assign hit_c         = valid_q[index] && (tag_q[index] == tag);
  assign read_hit_c    = (state_q == IDLE) && cpu_read && !cpu_write && hit_c;
  assign fill_done_c   = (state_q == FILL) && mem_ready;
  assign write_done_c  = (state_q == WRITE) && mem_ready;
  assign word_base_c   = {offset, 4'b0000};
  assign cached_word_c = data_q[index][word_base_c +: WORD_W];
  assign fill_word_c   = mem_rdata[word_base_c +: WORD_W];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a store takes priority over a simultaneous load
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_write)                state_d = WRITE;
        else if (cpu_read && !hit_c)  state_d = FILL;
      end
      FILL:    if (mem_ready) state_d = IDLE;
      WRITE:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; fill data is forwarded to the CPU in the completing cycle
  always_comb begin
    cpu_ready   = 1'b0;
    cpu_rdata   = 16'h0000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 16'h0000;
    mem_wdata   = 16'h0000;
    case (state_q)
      IDLE: begin
        if (read_hit_c) begin
          cpu_ready = 1'b1;
          cpu_rdata = cached_word_c;
        end
      end
      FILL: begin
        mem_read    = 1'b1;
        mem_address = {tag, index, 2'b00};
        if (mem_ready) begin
          cpu_ready = 1'b1;
          cpu_rdata = fill_word_c;
        end
      end
      WRITE: begin
        mem_write   = 1'b1;
        mem_address = cpu_address;
        mem_wdata   = cpu_wdata;
        cpu_ready   = mem_ready;
      end
      default: ;
    endcase
  end

  // Valid bits and performance counters
  always_comb begin
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (fill_done_c) begin
      valid_d[index] = 1'b1;
      miss_count_d   = miss_count_q + 16'd1;
    end
    if (read_hit_c || (write_done_c && hit_c)) hit_count_d = hit_count_q + 16'd1;
    if (write_done_c && !hit_c) miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays carry no reset; validity alone gates their use
  always_ff @(posedge clk) begin
    if (fill_done_c) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_rdata;
    end else if (write_done_c && hit_c) begin
      data_q[index][word_base_c +: WORD_W] <= cpu_wdata;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipelined datapath's data-memory port (MEM stage) and the external data memory. MEM-stage loads and stores are presented on the CPU side. A read hit completes in the same cycle. Misses and all writes go to memory through a ready-handshake, and the cache drops `cpu_ready` to stall the pipeline meanwhile. Lines are 4 words of 16 bits and fill in one memory transfer; hit and miss counters are provided for performance reporting.

## Interface
- `INDEX_BITS`, 2, number of index bits; the cache has 2^INDEX_BITS lines. Offset is fixed at 2 bits and the tag is the remaining 14-INDEX_BITS bits.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `cpu_read`  in  1  load request from the MEM stage.
- `cpu_write`  in  1  store request from the MEM stage.
- `cpu_address`  in  16  word address.
- `cpu_wdata`  in  16  store data.
- `cpu_rdata`  out  16  load data; valid only when `cpu_ready`=1, otherwise 0.
- `cpu_ready`  out  1  access completes this cycle; while 0 the pipeline stalls.
- `mem_read`  out  1  line-fill request.
- `mem_write`  out  1  word write request.
- `mem_address`  out  16  fill address {tag,index,2'b00} or the write word address.
- `mem_wdata`  out  16  write data.
- `mem_rdata`  in  64  fill line; word k is at bits [16k+15:16k].
- `mem_ready`  in  1  one-cycle completion strobe for the outstanding request.
- `hit_count`  out  16  completed hits.
- `miss_count`  out  16  completed misses.

## Operation
- Address split: offset = `cpu_address[1:0]`, index = `cpu_address[INDEX_BITS+1:2]`, tag = the upper bits.
- hit = valid[index] && tag_store[index]==tag.
- Request priority: if `cpu_read` and `cpu_write` are both asserted, the access is a write.
- The CPU holds the request and its address and data stable until `cpu_ready`=1.

FSM states: IDLE, FILL, WRITE.
- **IDLE, no request:** `cpu_ready`=0 and no memory request is issued.
- **IDLE, read hit:** `cpu_ready`=1 combinationally and `cpu_rdata` is the selected word. `hit_count` increments at the edge. State stays IDLE.
- **IDLE, read miss:** `cpu_ready`=0; go to FILL.
- **IDLE, write:** `cpu_ready`=0; go to WRITE.
- **FILL:**
  - `mem_read`=1 and `mem_address`={tag,index,00}.
  - On `mem_ready`=1: `cpu_ready`=1 and `cpu_rdata`=`mem_rdata` word[offset], forwarded combinationally. At the same edge the line, tag and valid bit are written, `miss_count` increments, and the state returns to IDLE.
- **WRITE:**
  - `mem_write`=1, `mem_address`=`cpu_address`, `mem_wdata`=`cpu_wdata`.
  - On `mem_ready`=1: `cpu_ready`=1. On a write hit the cached word is updated and `hit_count` increments. On a write miss no allocation is made and `miss_count` increments. The state returns to IDLE.
- `mem_read`, `mem_write` and `mem_address` are decoded from the state and the held request. Outside FILL and WRITE both request strobes are 0 and `mem_address` is 0.
- `mem_ready` is ignored in IDLE.
- Both counters wrap from 16'hFFFF to 0.

## Timing
- Reset (async, immediate):
  - State is IDLE and all valid bits are 0.
  - Both counters are 0.
  - `cpu_ready`, `mem_read` and `mem_write` are 0; `cpu_rdata`, `mem_address` and `mem_wdata` are 0.
  - Tag and data arrays are not reset.
- Reset mid-FILL or mid-WRITE: the request strobes drop immediately. A `mem_ready` arriving after reset is ignored, and the line is not written.
- Read hit: 0 stall cycles; completes in the cycle it is presented.
- Read miss or any write: the request is presented in cycle t and FILL/WRITE is entered at edge t+1. If `mem_ready` arrives in cycle t+L (L≥1), `cpu_ready`=1 in cycle t+L, so there are L stall cycles.
- A new request may be presented in the cycle after `cpu_ready`. A read of a just-filled line in that cycle hits.
- Back-to-back reads of the same line: the first misses and every subsequent one hits with no gap.

## Test plan
- **Reset values:** assert `reset_n`=0 asynchronously between edges -> all outputs and counters read 0 immediately.
- **Miss then hit:**
  - Memory latency 3; read 0x0005 with the line at 0x0004 = {0x4444,0x3333,0x2222,0x1111}.
  - Required: `mem_read` with `mem_address`=0x0004 for 3 cycles, then `cpu_rdata`=0x2222 with `cpu_ready`=1, and `miss_count`=1.
  - Next read 0x0007 -> same-cycle `cpu_ready`, `cpu_rdata`=0x4444, `hit_count`=1.
- **Conflict eviction:** read 0x0000, then 0x0010 (same index 0), then 0x0000 -> three fills, `miss_count`=3, `hit_count`=0.
- **Write hit:**
  - Write 0xBEEF to 0x0005 after the line is cached.
  - Required: `mem_write`=1 with `mem_address`=0x0005 and `mem_wdata`=0xBEEF until `mem_ready`; a subsequent read of 0x0005 hits with 0xBEEF.
  - `hit_count` increments for both the write and the read.
- **Write miss:** write to uncached 0x0020, then read 0x0020 -> the read misses and fills (no allocate on the write); `miss_count` increments by 2.
- **Reset mid-fill:** pulse `reset_n` low during FILL, then assert `mem_ready` -> no `cpu_ready`, the line stays invalid, and the next read of that address misses.
